// File: rtl/ifm_buf_pkg.sv
// ifm_buf_pkg: shared definitions for the IFM read-channel responder.
//   RSP_FIFO_DEPTH : number of response slots, which is also the request credit limit
//   IFM_WORD_W     : width of the data field in a response entry (DN*DW at the default build)
//   rsp_entry_t    : one queued response {data, first, last}
//   idx_width()    : address/pointer width needed to index a given number of entries
package ifm_buf_pkg;

    localparam int RSP_FIFO_DEPTH = 3;
    localparam int IFM_WORD_W     = 64;

    typedef struct packed {
        logic [IFM_WORD_W-1:0] data;
        logic                  first;
        logic                  last;
    } rsp_entry_t;

    // A single-entry store still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifm_rsp_fifo.sv
// ifm_rsp_fifo: synchronous FIFO of arbitrary (not necessarily power-of-two) depth.
//   clk, rst_n        : clock, asynchronous active-low reset (pointers and count only)
//   push, push_data   : write an entry; accepted when not full, or when full and popping
//   pop               : drop the head entry; ignored when empty
//   head_data         : current head entry (undefined when count is zero)
//   count             : number of valid entries
module ifm_rsp_fifo
    import ifm_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    // When full, a push is only legal alongside a pop; the freed slot is the one
    // being written, and the head is read combinationally before the edge.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    assign head_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifm_buf_rsp.sv
// ifm_buf_rsp: in-order responder for the conv core's input-feature-map read channel.
// Each accepted ifm_addr request returns one DN*DW-bit word from a local buffer,
// two cycles later when the response queue is empty.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   ifm_addr, ifm_addr_first/last      : request word address and burst markers
//   ifm_addr_valid / ifm_addr_ready    : request handshake (ready is credit based)
//   ifm_data, ifm_first, ifm_last      : response word and echoed burst markers
//   ifm_valid / ifm_ready              : response handshake
//   wr_en, wr_addr, wr_data            : loader write port, independent of reads
//   err_oob                            : sticky out-of-range request flag
// Build option IFM_BUF_OOB_CHK_EN: when defined, addresses >= DEPTH read as zero,
// set err_oob, and writes to them are dropped; otherwise addresses wrap and err_oob is 0.
// DN*DW is expected to equal IFM_WORD_W from ifm_buf_pkg.
module ifm_buf_rsp
    import ifm_buf_pkg::*;
#(
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int DN    = 8,
    parameter int DEPTH = 16384
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      ifm_addr,
    input  logic               ifm_addr_first,
    input  logic               ifm_addr_last,
    input  logic               ifm_addr_valid,
    output logic               ifm_addr_ready,
    output logic [DN*DW-1:0]   ifm_data,
    output logic               ifm_first,
    output logic               ifm_last,
    output logic               ifm_valid,
    input  logic               ifm_ready,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DN*DW-1:0]   wr_data,
    output logic               err_oob
);

    localparam int WORD_W  = DN * DW;
    localparam int IW      = idx_width(DEPTH);
    localparam int ENTRY_W = $bits(rsp_entry_t);
    localparam int CNT_W   = $clog2(RSP_FIFO_DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     wr_idx;
    logic              rd_oob;
    logic              wr_ok;
    logic              accept;

    logic              vld_p1;
    logic [WORD_W-1:0] data_p1;
    logic              first_p1;
    logic              last_p1;

    rsp_entry_t        push_entry;
    rsp_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    credit_used;

    assign rd_idx = ifm_addr[IW-1:0];
    assign wr_idx = wr_addr[IW-1:0];

    generate
        if (AW > IW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{ifm_addr[AW-1:IW], wr_addr[AW-1:IW]};
        end
    endgenerate

`ifdef IFM_BUF_OOB_CHK_EN
    assign rd_oob = ({1'b0, ifm_addr} >= (AW+1)'(DEPTH));
    assign wr_ok  = wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
`else
    assign rd_oob = 1'b0;
    assign wr_ok  = wr_en;
`endif

    // Credits count both queued words and the word still being read, so the
    // queue can never be pushed while full; ready depends on registers only.
    assign credit_used    = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(vld_p1);
    assign ifm_addr_ready = (credit_used < (CNT_W+1)'(RSP_FIFO_DEPTH));
    assign accept         = ifm_addr_valid && ifm_addr_ready;

    // ---- stage p1: RAM read (read-first against a same-cycle write) ----
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
        if (accept) begin
            data_p1  <= rd_oob ? '0 : mem[rd_idx];
            first_p1 <= ifm_addr_first;
            last_p1  <= ifm_addr_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

`ifdef IFM_BUF_OOB_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oob <= 1'b0;
        end else if (accept && rd_oob) begin
            err_oob <= 1'b1;
        end
    end
`else
    assign err_oob = 1'b0;
`endif

    // ---- stage p2: response queue, head drives the output channel ----
    assign push_entry.data  = IFM_WORD_W'(data_p1);
    assign push_entry.first = first_p1;
    assign push_entry.last  = last_p1;

    ifm_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (push_entry),
        .pop       (ifm_valid && ifm_ready),
        .head_data (head_bits),
        .count     (fifo_cnt)
    );

    assign head_entry = rsp_entry_t'(head_bits);
    assign ifm_valid  = (fifo_cnt != '0);

    // Outputs read zero whenever nothing is presented, which also gives the
    // all-zero reset values without resetting the queue storage.
    assign ifm_data  = ifm_valid ? WORD_W'(head_entry.data) : '0;
    assign ifm_first = ifm_valid && head_entry.first;
    assign ifm_last  = ifm_valid && head_entry.last;

endmodule

// File: tb/tb_ifm_buf_rsp.sv
module tb_ifm_buf_rsp;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int DN    = 8;
    localparam int DEPTH = 1024;
    localparam int WW    = DN * DW;

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  ifm_addr;
    logic           ifm_addr_first;
    logic           ifm_addr_last;
    logic           ifm_addr_valid;
    logic           ifm_addr_ready;
    logic [WW-1:0]  ifm_data;
    logic           ifm_first;
    logic           ifm_last;
    logic           ifm_valid;
    logic           ifm_ready;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [WW-1:0]  wr_data;
    logic           err_oob;

    ifm_buf_rsp #(
        .AW    (AW),
        .DW    (DW),
        .DN    (DN),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifm_addr       (ifm_addr),
        .ifm_addr_first (ifm_addr_first),
        .ifm_addr_last  (ifm_addr_last),
        .ifm_addr_valid (ifm_addr_valid),
        .ifm_addr_ready (ifm_addr_ready),
        .ifm_data       (ifm_data),
        .ifm_first      (ifm_first),
        .ifm_last       (ifm_last),
        .ifm_valid      (ifm_valid),
        .ifm_ready      (ifm_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .err_oob        (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [WW-1:0] data;
        bit            first;
        bit            last;
        int            cyc;
        bit            exact;
    } exp_t;

    exp_t sb[$];

    // Reference buffer contents as the loader has written them.
    logic [WW-1:0] model_mem [DEPTH];

    function automatic logic [WW-1:0] model_read(input int a);
`ifdef IFM_BUF_OOB_CHK_EN
        if (a >= DEPTH) return '0;
        return model_mem[a];
`else
        return model_mem[a % DEPTH];
`endif
    endfunction

    task automatic model_write(input int a, input logic [WW-1:0] d);
`ifdef IFM_BUF_OOB_CHK_EN
        if (a < DEPTH) model_mem[a] = d;
`else
        model_mem[a % DEPTH] = d;
`endif
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus. Inputs change just after the rising edge; the
    // handshake outcome is decided from ready at the falling edge, where the
    // expected response is queued before the same cycle's write reaches the model.
    task automatic drive_cycle(input bit v, input int a, input bit f, input bit l,
                               input bit we, input int wa, input logic [WW-1:0] wd,
                               input bit rdy, input bit ex);
        exp_t e;
        ifm_addr_valid = v;
        ifm_addr       = AW'(a);
        ifm_addr_first = f;
        ifm_addr_last  = l;
        wr_en          = we;
        wr_addr        = AW'(wa);
        wr_data        = wd;
        ifm_ready      = rdy;
        @(negedge clk);
        if (v && ifm_addr_ready) begin
            e.data  = model_read(a);
            e.first = f;
            e.last  = l;
            e.cyc   = cyc;
            e.exact = ex;
            sb.push_back(e);
            acc_cnt++;
        end
        if (we) model_write(wa, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, '0, rdy, 0);
    endtask

    // Monitor: pops the scoreboard on every completed response handshake.
    bit            prev_hold = 0;
    logic [WW+1:0] prev_word;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk_int("hold_valid", int'(ifm_valid), 1);
                chk_word("hold_word", ifm_data, prev_word[WW-1:0]);
                chk_int("hold_first_last", int'({ifm_first, ifm_last}), int'(prev_word[WW+1:WW]));
            end
            if (ifm_valid && ifm_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %h with no request outstanding (cycle %0d)", ifm_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk_word("rsp_data", ifm_data, e.data);
                    chk_int("rsp_first_last", int'({ifm_first, ifm_last}), int'({e.first, e.last}));
                    lat = cyc - e.cyc;
                    if (e.exact) chk_int("rsp_latency", lat, 2);
                    else         chk_int("rsp_latency_min", int'(lat >= 2), 1);
                end
            end
            prev_hold = ifm_valid && !ifm_ready;
            prev_word = {ifm_first, ifm_last, ifm_data};
        end
    end

    initial begin
        int base;
        rst_n          = 1'b1;
        ifm_addr       = '0;
        ifm_addr_first = 1'b0;
        ifm_addr_last  = 1'b0;
        ifm_addr_valid = 1'b0;
        ifm_ready      = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #2;
        chk_int("reset_valid", int'(ifm_valid), 0);
        chk_word("reset_data", ifm_data, '0);
        chk_int("reset_first_last", int'({ifm_first, ifm_last}), 0);
        chk_int("reset_err_oob", int'(err_oob), 0);
        chk_int("reset_addr_ready", int'(ifm_addr_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill the whole buffer with random words
        for (int i = 0; i < DEPTH; i++)
            drive_cycle(0, 0, 0, 0, 1, i, {$urandom, $urandom}, 1, 0);

        // In-order burst, back to back, fixed two-cycle latency
        for (int i = 0; i < 4; i++)
            drive_cycle(0, 0, 0, 0, 1, i, {8{8'(8'h11 * (i + 1))}}, 1, 0);
        for (int i = 0; i < 4; i++)
            drive_cycle(1, i, i == 0, i == 3, 0, 0, '0, 1, 1);
        chk_word("burst_model_word3", model_read(3), {8{8'h44}});
        idle(4, 1);
        chk_int("burst_drained", sb.size(), 0);

        // Backpressure: only the credit limit is accepted
        base = acc_cnt;
        for (int i = 0; i < 8; i++)
            drive_cycle(1, 10 + i, 0, 0, 0, 0, '0, 0, 0);
        chk_int("bp_accepts", acc_cnt - base, 3);
        chk_int("bp_addr_ready_low", int'(ifm_addr_ready), 0);
        chk_int("bp_valid_held", int'(ifm_valid), 1);
        drive_cycle(0, 0, 0, 0, 0, 0, '0, 1, 0);
        chk_int("bp_addr_ready_back", int'(ifm_addr_ready), 1);
        idle(4, 1);
        chk_int("bp_drained", sb.size(), 0);

        // Same-cycle read and write of one address returns the old word
        drive_cycle(1, 5, 1, 1, 1, 5, {8{8'hAA}}, 1, 1);
        drive_cycle(1, 5, 0, 0, 0, 0, '0, 1, 1);
        chk_word("rfw_model_new", model_read(5), {8{8'hAA}});
        idle(4, 1);

        // Address at DEPTH: zero + sticky flag, or wrap to word 0
        drive_cycle(1, DEPTH, 1, 0, 0, 0, '0, 1, 1);
        idle(3, 1);
`ifdef IFM_BUF_OOB_CHK_EN
        chk_int("oob_err_set", int'(err_oob), 1);
        idle(5, 1);
        chk_int("oob_err_sticky", int'(err_oob), 1);
`else
        chk_int("oob_err_zero", int'(err_oob), 0);
        idle(5, 1);
        chk_int("oob_err_still_zero", int'(err_oob), 0);
`endif

        // Reset with two responses queued
        drive_cycle(1, 20, 0, 0, 0, 0, '0, 0, 0);
        drive_cycle(1, 21, 0, 0, 0, 0, '0, 0, 0);
        idle(2, 0);
        chk_int("pre_reset_valid", int'(ifm_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_int("mid_reset_valid", int'(ifm_valid), 0);
        chk_int("mid_reset_err_oob", int'(err_oob), 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_int("post_reset_addr_ready", int'(ifm_addr_ready), 1);
        drive_cycle(1, 7, 1, 1, 0, 0, '0, 1, 1);
        idle(4, 1);
        chk_int("post_reset_drained", sb.size(), 0);

        // Random traffic against the scoreboard
        base = acc_cnt;
        for (int k = 0; k < 40000 && (acc_cnt - base) < 10000; k++) begin
            drive_cycle(($urandom % 10) < 7, int'($urandom_range(0, DEPTH + 127)),
                        $urandom % 2, $urandom % 2,
                        ($urandom % 4) == 0, int'($urandom_range(0, DEPTH + 127)),
                        {$urandom, $urandom}, ($urandom % 10) < 7, 0);
        end
        chk_int("random_accepts", acc_cnt - base, 10000);

        for (int k = 0; k < 30 && sb.size() != 0; k++) idle(1, 1);
        idle(2, 1);
        chk_int("final_drained", sb.size(), 0);
        chk_int("final_valid", int'(ifm_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
